// File: rtl/f_pc_sequencer.sv
// Fetch-stage PC controller: owns the fetch PC, drives the imem valid/ready request
// and merges exception / eret / buffered redirect / branch / sequential next-PC sources.
// Optional macro PC_ALIGN_CHECK_EN: misaligned next PCs are replaced by EXC_VECTOR and flagged on addr_err.
module f_pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        D_redirect,
  input  logic [31:0] D_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] F_pc,
  output logic        F_valid,
  output logic        flush_D,
  output logic        addr_err
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]  r_state;
  logic        r_req;
  logic [31:0] r_pc;
  logic        r_pend_valid;
  logic [31:0] r_pend_pc;
  logic        r_kill;
  logic        r_addr_err;

  logic [1:0]  w_next_state;
  logic        w_hs;
  logic        w_load;
  logic [31:0] w_sel_pc;
  logic        w_misalign;
  logic [31:0] w_next_pc;

  assign w_hs   = r_req & imem_ready;
  assign w_load = w_hs & ~stall;

  // Next-state decode of the BOOT/FETCH/HOLD sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_BOOT: w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (stall && !w_hs) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: w_next_state = ST_BOOT;
    endcase
  end

  // Priority merge of next-PC sources
  always_comb begin
    w_sel_pc = r_pc + 32'd4;
    if (exc_req) begin
      w_sel_pc = EXC_VECTOR;
    end else if (eret_req) begin
      w_sel_pc = epc;
    end else if (r_pend_valid) begin
      w_sel_pc = r_pend_pc;
    end else if (D_redirect) begin
      w_sel_pc = D_target;
    end else begin
      w_sel_pc = r_pc + 32'd4;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign w_misalign = (w_sel_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_next_pc = w_misalign ? EXC_VECTOR : w_sel_pc;

  // FSM, request flag and architectural PC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_BOOT;
      r_req      <= 1'b0;
      r_pc       <= RESET_PC;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_req      <= (w_next_state == ST_FETCH);
      r_addr_err <= w_load & w_misalign;
      if (w_load) begin
        r_pc <= w_next_pc;
      end else begin
        r_pc <= r_pc;
      end
    end
  end

  // Pending-redirect buffer; exception/eret override a stored branch and kill the in-flight fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_valid <= 1'b0;
      r_pend_pc    <= RESET_PC;
      r_kill       <= 1'b0;
    end else if (w_load) begin
      r_pend_valid <= 1'b0;
      r_kill       <= 1'b0;
    end else if (exc_req) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= EXC_VECTOR;
      r_kill       <= 1'b1;
    end else if (eret_req) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= epc;
      r_kill       <= 1'b1;
    end else if (D_redirect && !r_kill) begin
      r_pend_valid <= 1'b1;
      r_pend_pc    <= D_target;
    end else begin
      r_pend_valid <= r_pend_valid;
      r_pend_pc    <= r_pend_pc;
      r_kill       <= r_kill;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;
  assign F_pc      = r_pc;
  assign F_valid   = w_hs & ~stall & ~r_kill & ~exc_req & ~eret_req;
  assign flush_D   = exc_req | eret_req;
  assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Scoreboard bench for f_pc_sequencer: a behavioural fetch model queues expected fetches,
// deliveries and per-cycle flags; a negedge monitor pops and compares them.
module tb_f_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] VEC    = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        D_redirect = 1'b0;
  logic [31:0] D_target = 32'h0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] F_pc;
  logic        F_valid;
  logic        flush_D;
  logic        addr_err;

  f_pc_sequencer #(.RESET_PC(RST_PC), .EXC_VECTOR(VEC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .D_redirect(D_redirect),
    .D_target(D_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .F_pc(F_pc), .F_valid(F_valid), .flush_D(flush_D), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  logic [31:0] q_fetch[$];
  logic [31:0] q_deliv[$];
  logic [2:0]  q_flag[$];

  // Behavioural fetch model: where fetch is, what is waiting to be jumped to
  bit          m_fetching;
  logic [31:0] m_pc;
  bit          m_have_jump;
  logic [31:0] m_jump;
  bit          m_drop_next;
  bit          m_aerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One clock of stimulus plus the model's prediction for that cycle
  task automatic cyc(input bit rdy, input bit st, input bit rd, input logic [31:0] tg,
                     input bit ex, input bit er, input logic [31:0] ep);
    bit          took;
    logic [31:0] nxt;
    @(posedge clk);
    #1;
    imem_ready = rdy; stall = st; D_redirect = rd; D_target = tg;
    exc_req = ex; eret_req = er; epc = ep;
    q_flag.push_back({m_fetching, m_aerr, ex | er});
    took = m_fetching && rdy;
    if (took) q_fetch.push_back(m_pc);
    m_aerr = 1'b0;
    if (took && !st) begin
      if (!m_drop_next && !ex && !er) q_deliv.push_back(m_pc);
      if (ex)               nxt = VEC;
      else if (er)          nxt = ep;
      else if (m_have_jump) nxt = m_jump;
      else if (rd)          nxt = tg;
      else                  nxt = m_pc + 32'd4;
`ifdef PC_ALIGN_CHECK_EN
      if (nxt % 4 != 0) begin
        nxt = VEC;
        m_aerr = 1'b1;
      end
`endif
      m_pc = nxt;
      m_have_jump = 1'b0;
      m_drop_next = 1'b0;
    end else if (ex || er) begin
      m_have_jump = 1'b1;
      m_jump = ex ? VEC : ep;
      m_drop_next = 1'b1;
    end else if (rd && !m_drop_next) begin
      m_have_jump = 1'b1;
      m_jump = tg;
    end
    if (m_fetching) m_fetching = !(st && !took);
    else            m_fetching = !st;
    run = 1'b1;
  endtask

  // Monitor: compares DUT outputs against queued expectations
  always @(negedge clk) begin
    if (run) begin
      if (q_flag.size() == 0) begin
        chk("flag_queue_underflow", 32'd1, 32'd0);
      end else begin
        chk("req_aerr_flush", {29'd0, imem_req, addr_err, flush_D}, {29'd0, q_flag.pop_front()});
      end
      if (imem_req && imem_ready) begin
        if (q_fetch.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
        else chk("fetch_addr", imem_addr, q_fetch.pop_front());
      end
      if (F_valid) begin
        if (q_deliv.size() == 0) chk("unexpected_delivery", F_pc, 32'hFFFF_FFFF);
        else chk("deliv_pc", F_pc, q_deliv.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t;
    logic [31:0] e;
    #12;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_F_pc", F_pc, RST_PC);
    chk("rst_F_valid", {31'd0, F_valid}, 32'd0);
    chk("rst_flush_D", {31'd0, flush_D}, 32'd0);
    chk("rst_addr_err", {31'd0, addr_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("boot_no_req", {31'd0, imem_req}, 32'd0);
    m_fetching = 1'b1; m_pc = RST_PC; m_have_jump = 1'b0; m_jump = 32'h0;
    m_drop_next = 1'b0; m_aerr = 1'b0;

    repeat (3) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) cyc(0, 0, 1, 32'h3100, 0, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(0, 0, 0, 32'h0, 1, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) cyc(1, 1, 0, 32'h0, 0, 0, 32'h0);
    repeat (3) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h3100, 1, 1, 32'h3020);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h3102, 0, 0, 32'h0);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      t = {20'h00003, $urandom_range(1023, 0), 2'b00};
      if ($urandom_range(9, 0) == 0) t[1:0] = 2'($urandom_range(3, 1));
      e = {20'h00003, $urandom_range(1023, 0), 2'b00};
      cyc($urandom_range(9, 0) < 7, $urandom_range(99, 0) < 15, $urandom_range(99, 0) < 15, t,
          $urandom_range(99, 0) < 4, $urandom_range(99, 0) < 4, e);
    end
    cyc(1, 0, 0, 32'h0, 0, 0, 32'h0);

    @(negedge clk);
    #1;
    run = 1'b0;
    chk("fetch_queue_drained", q_fetch.size(), 32'd0);
    chk("deliv_queue_drained", q_deliv.size(), 32'd0);

    imem_ready = 1'b1; stall = 1'b0; exc_req = 1'b0; eret_req = 1'b0; D_redirect = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("midrst_imem_addr", imem_addr, RST_PC);
    chk("midrst_F_valid", {31'd0, F_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
